// File: rtl/clk_div_sequencer.sv
// Programmable clock-enable sequencer: emits a one-cycle tick and a 50% outClk
// every div_eff cycles under run / stop / single-step control.
module clk_div_sequencer #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned DEFAULT_DIV = 4
) (
   input  logic             inClk,
   input  logic             reset,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_div,
   output logic             cfg_ready,
   input  logic             run,
   input  logic             step,
   output logic             tick,
   output logic             outClk,
   output logic             busy,
   output logic [WIDTH-1:0] count
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] RUN      = 2'd1;
   localparam logic [1:0] STOPPING = 2'd2;
   localparam logic [1:0] STEP     = 2'd3;

   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             outclk_q, outclk_d;

   logic [WIDTH-1:0] div_eff;
   logic             wrap;
   logic             counting;
   logic             cfg_xfer;

   // A zero divisor behaves as divide-by-one, so cnt can never run past div_eff-1.
   assign div_eff  = (div_q == '0) ? ONE : div_q;
   assign wrap     = (cnt_q == (div_eff - ONE));
   assign counting = (state_q != IDLE);

   assign cfg_ready = (state_q == IDLE) || ((state_q == RUN) && wrap);
   assign cfg_xfer  = cfg_valid && cfg_ready;

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      cnt_d    = cnt_q;
      tick_d   = 1'b0;
      outclk_d = outclk_q;

      if (cfg_xfer) begin
         div_d = cfg_div;
      end

      if (counting) begin
         if (wrap) begin
            cnt_d    = '0;
            tick_d   = 1'b1;
            outclk_d = ~outclk_q;
         end else begin
            cnt_d    = cnt_q + ONE;
         end
      end

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (run) begin
               state_d = RUN;
            end else if (step) begin
               state_d = STEP;
            end
         end
         RUN: begin
            if (!run) begin
               state_d = STOPPING;
            end
         end
         STOPPING: begin
            // Re-asserting run resumes without disturbing the current period.
            if (run) begin
               state_d = RUN;
            end else if (wrap) begin
               state_d = IDLE;
            end
         end
         STEP: begin
            if (wrap) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge inClk) begin
      if (reset) begin
         state_q  <= IDLE;
         div_q    <= DIV_RST;
         cnt_q    <= '0;
         tick_q   <= 1'b0;
         outclk_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
         outclk_q <= outclk_d;
      end
   end

   assign tick   = tick_q;
   assign outClk = outclk_q;
   assign busy   = (state_q != IDLE);
   assign count  = cnt_q;

endmodule

// File: doc/clk_div_sequencer.md
# clk_div_sequencer

Run-controlled, reprogrammable clock-enable sequencer for the lab FPGA boards. It slows board-clock activity so results are visible, and replaces a fixed divide-by-N with a programmable divisor loaded through a valid/ready handshake. It provides run, stop and single-step control and emits a one-cycle `tick` enable plus a 50%-duty `outClk`. It sits between the board clock and the demo datapaths, which are clocked by `inClk` and qualified by `tick`.

## Interface
- `WIDTH`, 16: width of the divisor and counter.
- `DEFAULT_DIV`, 4: divisor loaded at reset.
- `inClk`  in  1: board clock. Only clock in the block.
- `reset`  in  1: synchronous, active-high reset.
- `cfg_valid`  in  1: a new divisor is presented on `cfg_div`.
- `cfg_div`  in  WIDTH: requested divisor. Value 0 is treated as 1.
- `cfg_ready`  out  1: block can accept `cfg_div` this cycle (combinational).
- `run`  in  1: level, free-running enable.
- `step`  in  1: level, sampled only in IDLE; requests exactly one period.
- `tick`  out  1: registered, one-cycle pulse at each period end.
- `outClk`  out  1: registered, toggles at each period end (period = 2·div cycles).
- `busy`  out  1: state ≠ IDLE (combinational from state).
- `count`  out  WIDTH: current counter value.

## Operation
- Registers: `state`, `div`, `cnt`, `tick`, `outClk`. `div_eff = (div == 0) ? 1 : div`.
- `wrap = (cnt == div_eff-1)`.
- States are IDLE, RUN, STOPPING and STEP.
- IDLE:
  - `cnt` is held at 0 and `tick` is 0.
  - `run=1` → RUN.
  - Else `step=1` → STEP. If both are high, run wins.
- RUN, STOPPING, STEP all count:
  - On each edge, if `wrap`: `cnt←0`, `tick←1`, `outClk←~outClk`.
  - Otherwise `cnt←cnt+1`, `tick←0`.
- RUN:
  - `run=0` → STOPPING. `cnt` is not reset.
  - `step` is ignored.
- STOPPING:
  - Finishes the current period. At the `wrap` edge → IDLE.
  - `run=1` before wrap → RUN, and counting continues uninterrupted.
- STEP: at the `wrap` edge → IDLE. `run` is ignored until IDLE.
- `cfg_ready = (state==IDLE) | (state==RUN & wrap)`.
  - Transfer happens when `cfg_valid & cfg_ready`; `div←cfg_div` at that edge.
  - In RUN, the new divisor governs the period that starts after the wrap. A period is never shortened or stretched mid-way.
  - `cfg_ready` is 0 in STOPPING and STEP. A pending `cfg_valid` waits; the source must hold `cfg_div` stable until the transfer.
- `outClk` keeps its level when the block stops. It is never forced low except by reset.
- Reset mid-operation aborts immediately. No final tick is produced and any pending config is dropped.

## Timing
- Reset values: state=IDLE, `div=DEFAULT_DIV`, `cnt=0`, `tick=0`, `outClk=0`, `busy=0`, `count=0`, `cfg_ready=1`.
- `run` sampled high at edge k → RUN after edge k, with `cnt=0`.
  - First `tick` is high after edge k+D, where D = `div_eff`.
  - Subsequent ticks follow edges k+2D, k+3D, and so on.
- `div_eff=1`: `tick` stays high continuously while running, and `outClk` toggles every cycle.
- STEP from edge k: exactly one `tick` after edge k+D. `busy` drops at the same edge.
- STOPPING: the final `tick` coincides with the return to IDLE, so `busy=0` in the same cycle `tick=1`.
- Config latency:
  - Accepted at edge j in IDLE: the new divisor applies to the next start.
  - Accepted at a RUN wrap edge j: the next tick is at j+new_div.
- `cnt` never exceeds `div_eff-1`. No overflow is possible for any `cfg_div` in [0, 2^WIDTH-1].

## Test plan
- Reset with `run=0`, then hold idle 10 cycles → `outClk=0`, `tick=0`, `count=0`, `cfg_ready=1`, `busy=0` throughout.
- `div=4`, `run` high from edge 0 → ticks after edges 4, 8, 12. `outClk` rises after 4, falls after 8, and has period 8.
- RUN with `div=4`, `cfg_valid=1`, `cfg_div=2` held from edge 5 → `cfg_ready` high only at wrap edge 8. Ticks follow edges 8, 10, 12.
- `cfg_div=0`, `run=1` → `tick` high every cycle and `outClk` toggles every cycle.
- `div=5`, run from edge 0, `run` dropped after edge 2 → STOPPING. Final tick after edge 5, then IDLE with `outClk=1` retained. `step=1` then gives one tick 5 cycles later with `outClk=0`.
- `div=6` running, `reset` pulsed at edge 3 → immediate IDLE, `outClk=0`, `div=DEFAULT_DIV`, and no tick.
